bp_be_redirect_ctl: RTL

Backend sequencer sitting between the control (branch) pipe and the frontend interface. Compares each resolved branch target against the predicted next PC, holds a single pending mispredict redirect until the frontend accepts it, and stalls dispatch meanwhile. Queues branch-training updates for the frontend predictor in a small lossy FIFO, independent of the redirect channel.

---
 rtl/bp_be_pkg.sv | 29 ++
 rtl/bsg_fifo_1r1w_small.sv | 52 +++++
 rtl/bp_be_redirect_ctl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/bp_be_pkg.sv
// Shared types for the backend redirect sequencer: processor config, FSM states and
// the branch-training entry carried to the frontend predictor.
`define BP_BE_BRANCH_UPDATE_WIDTH(vaddr_mp) (2*(vaddr_mp)+1)

package bp_be_pkg;

  typedef enum logic {e_bp_default_cfg} bp_params_e;

  localparam int vaddr_width_gp = 39;

  function automatic int bp_vaddr_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return vaddr_width_gp;
      default:          return vaddr_width_gp;
    endcase
  endfunction

  typedef enum logic {
    e_idle,
    e_redirect
  } bp_be_redirect_state_e;

  typedef struct packed {
    logic [vaddr_width_gp-1:0] pc;
    logic                      taken;
    logic [vaddr_width_gp-1:0] tgt;
  } bp_be_branch_update_s;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small lossy 1-read/1-write FIFO: a push into a full queue is dropped unless the
// head is popped in the same cycle. accept_o reports whether the push was taken.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               accept_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w = $clog2(els_p);

  logic [ptr_w:0]       r_wptr;
  logic [ptr_w:0]       r_rptr;
  logic [width_p-1:0]   r_mem [els_p];
  logic                 w_full;
  logic                 w_empty;
  logic                 w_enq;
  logic                 w_deq;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_full  = (r_wptr[ptr_w] != r_rptr[ptr_w]) &&
                   (r_wptr[ptr_w-1:0] == r_rptr[ptr_w-1:0]);
  assign w_empty = (r_wptr == r_rptr);
  assign w_deq   = yumi_i & ~w_empty;
  assign w_enq   = v_i & (~w_full | w_deq);

  assign accept_o = w_enq;
  assign v_o      = ~w_empty;
  assign data_o   = r_mem[r_rptr[ptr_w-1:0]];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + {{ptr_w{1'b0}}, 1'b1};
      if (w_deq) r_rptr <= r_rptr + {{ptr_w{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr[ptr_w-1:0]] <= data_i;
  end

endmodule

// File: rtl/bp_be_redirect_ctl.sv
// Backend redirect sequencer: holds one mispredict redirect until the frontend takes it
// and queues training updates. Optional counters enabled by BP_BE_REDIRECT_STATS_EN.
module bp_be_redirect_ctl
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p   = e_bp_default_cfg,
  parameter int         update_els_p  = 4,
  localparam int        vaddr_width_p = bp_vaddr_width(bp_params_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     br_v_i,
  input  logic                     br_branch_i,
  input  logic                     br_btaken_i,
  input  logic [vaddr_width_p-1:0] br_pc_i,
  input  logic [vaddr_width_p-1:0] br_npc_i,
  input  logic [vaddr_width_p-1:0] pred_npc_i,
  input  logic                     flush_i,
  output logic                     redirect_v_o,
  output logic [vaddr_width_p-1:0] redirect_npc_o,
  input  logic                     redirect_yumi_i,
  output logic                     update_v_o,
  output logic [vaddr_width_p-1:0] update_pc_o,
  output logic                     update_taken_o,
  output logic [vaddr_width_p-1:0] update_tgt_o,
  input  logic                     update_ready_i,
  output logic                     stall_o,
  output logic                     mispredict_o
`ifdef BP_BE_REDIRECT_STATS_EN
  ,
  output logic [31:0]              branch_cnt_o,
  output logic [31:0]              mispredict_cnt_o,
  output logic [31:0]              drop_cnt_o
`endif
);

  bp_be_redirect_state_e r_state;
  bp_be_redirect_state_e w_state_n;
  logic [vaddr_width_p-1:0] r_redirect_npc;
  logic                     r_mispredict;
  logic                     w_mispredict;
  logic                     w_capture;
  logic                     w_enq;
  logic                     w_fifo_accept;
  logic                     w_fifo_v;
  bp_be_branch_update_s     w_enq_data;
  bp_be_branch_update_s     w_head;

  assign w_mispredict = br_v_i & (br_npc_i != pred_npc_i);

  always_comb begin
    w_state_n = r_state;
    w_capture = 1'b0;
    w_enq     = 1'b0;
    case (r_state)
      e_idle: begin
        w_capture = w_mispredict & ~flush_i;
        w_enq     = br_v_i & br_branch_i & ~flush_i;
        if (w_capture) w_state_n = e_redirect;
      end
      // Flush and yumi both return to idle; on flush the held target is simply abandoned.
      e_redirect: begin
        if (flush_i | redirect_yumi_i) w_state_n = e_idle;
      end
      default: w_state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state        <= e_idle;
      r_redirect_npc <= '0;
      r_mispredict   <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_mispredict <= w_capture;
      if (w_capture) r_redirect_npc <= br_npc_i;
    end
  end

  assign redirect_v_o   = (r_state == e_redirect);
  assign stall_o        = (r_state == e_redirect);
  assign redirect_npc_o = r_redirect_npc;
  assign mispredict_o   = r_mispredict;

  assign w_enq_data.pc    = br_pc_i;
  assign w_enq_data.taken = br_btaken_i;
  assign w_enq_data.tgt   = br_npc_i;

  bsg_fifo_1r1w_small #(
    .width_p (`BP_BE_BRANCH_UPDATE_WIDTH(vaddr_width_gp)),
    .els_p   (update_els_p)
  ) u_update_fifo (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .v_i      (w_enq),
    .data_i   (w_enq_data),
    .accept_o (w_fifo_accept),
    .v_o      (w_fifo_v),
    .data_o   (w_head),
    .yumi_i   (w_fifo_v & update_ready_i)
  );

  // Head data is masked while empty so stale storage never leaks onto the bus.
  assign update_v_o     = w_fifo_v;
  assign update_pc_o    = w_fifo_v ? w_head.pc    : '0;
  assign update_taken_o = w_fifo_v ? w_head.taken : 1'b0;
  assign update_tgt_o   = w_fifo_v ? w_head.tgt   : '0;

`ifdef BP_BE_REDIRECT_STATS_EN
  logic [31:0] r_branch_cnt;
  logic [31:0] r_mispredict_cnt;
  logic [31:0] r_drop_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
      r_drop_cnt       <= '0;
    end else begin
      if (w_enq)                  r_branch_cnt     <= r_branch_cnt + 32'd1;
      if (w_capture)              r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
      if (w_enq & ~w_fifo_accept) r_drop_cnt       <= r_drop_cnt + 32'd1;
    end
  end

  assign branch_cnt_o     = r_branch_cnt;
  assign mispredict_cnt_o = r_mispredict_cnt;
  assign drop_cnt_o       = r_drop_cnt;
`else
  logic w_unused_accept;
  assign w_unused_accept = w_fifo_accept;
`endif

endmodule
